// File: rtl/alu_seq_if.sv
// Request/response bundle for the registered ALU: operands and opcode go in,
// result, NZCV flags and a one-cycle result strobe come back.
interface alu_seq_if #(
    parameter int BITS = 8
);
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      control_i;
    logic [BITS-1:0] bus_a_i;
    logic [BITS-1:0] bus_b_i;
    logic [BITS-1:0] bus_s_o;
    logic [3:0]      flags_o;
    logic            valid_o;

    modport master (
        output valid_i, control_i, bus_a_i, bus_b_i,
        input  ready_o, bus_s_o, flags_o, valid_o
    );

    modport slave (
        input  valid_i, control_i, bus_a_i, bus_b_i,
        output ready_o, bus_s_o, flags_o, valid_o
    );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle ops issue back-to-back, MUL runs as a
// BITS-cycle shift-add loop. Result and {N,Z,C,V} are registered and held.
module alu_seq #(
    parameter int BITS = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_seq_if.slave  alu
);
    localparam int              CW        = (BITS > 2) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0]   LAST      = CW'(BITS - 1);
    localparam logic [BITS:0]   SHIFT_MAX = (BITS + 1)'(BITS);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SHL = 4'd2, OP_SHR = 4'd3,
        OP_OR  = 4'd4, OP_AND = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
        OP_MUL = 4'd8
    } opcode_t;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg;
    logic [2*BITS-1:0]   acc_reg, mcand_reg;
    logic [BITS-1:0]     mplier_reg;
    logic [BITS-1:0]     res_reg;
    logic [3:0]          flags_reg;
    logic                valid_reg;

    logic                accept, is_mul, mul_last, shift_in_range;
    logic [BITS-1:0]     a, b, op_res;
    logic                op_c, op_v;
    logic [3:0]          op_flags;
    logic [BITS:0]       sum_ext, diff_ext, shl_ext, shr_ext;
    logic [2*BITS-1:0]   acc_step;

    assign a       = alu.bus_a_i;
    assign b       = alu.bus_b_i;
    assign accept  = alu.valid_i && (state_reg == IDLE);
    assign is_mul  = (alu.control_i == OP_MUL);
    assign mul_last = (count_reg == LAST);

    assign alu.ready_o = (state_reg == IDLE);
    assign alu.bus_s_o = res_reg;
    assign alu.flags_o = flags_reg;
    assign alu.valid_o = valid_reg;

    // Extended shifts keep the last bit shifted out in the extra position.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shl_ext  = {1'b0, a} << b;
    assign shr_ext  = {a, 1'b0} >> b;
    assign shift_in_range = (b != '0) && ({1'b0, b} <= SHIFT_MAX);

    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (alu.control_i)
            OP_ADD: begin
                op_res = sum_ext[BITS-1:0];
                op_c   = sum_ext[BITS];
                op_v   = (a[BITS-1] == b[BITS-1]) && (op_res[BITS-1] != a[BITS-1]);
            end
            OP_SUB: begin
                op_res = diff_ext[BITS-1:0];
                op_c   = ~diff_ext[BITS];
                op_v   = (a[BITS-1] != b[BITS-1]) && (op_res[BITS-1] != a[BITS-1]);
            end
            OP_SHL: begin
                if (b == '0) begin
                    op_res = a;
                end else if (shift_in_range) begin
                    op_res = shl_ext[BITS-1:0];
                    op_c   = shl_ext[BITS];
                end
            end
            OP_SHR: begin
                if (b == '0) begin
                    op_res = a;
                end else if (shift_in_range) begin
                    op_res = shr_ext[BITS:1];
                    op_c   = shr_ext[0];
                end
            end
            OP_OR:   op_res = a | b;
            OP_AND:  op_res = a & b;
            OP_XOR:  op_res = a ^ b;
            OP_NOT:  op_res = ~a;
            default: op_res = '0;
        endcase
        op_flags = {op_res[BITS-1], (op_res == '0), op_c, op_v};
    end

    assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && is_mul) state_next = MUL_RUN;
            MUL_RUN: if (mul_last)         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            res_reg    <= '0;
            flags_reg  <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    count_reg  <= '0;
                    acc_reg    <= '0;
                    mcand_reg  <= {{BITS{1'b0}}, a};
                    mplier_reg <= b;
                end else begin
                    res_reg   <= op_res;
                    flags_reg <= op_flags;
                    valid_reg <= 1'b1;
                end
            end else if (state_reg == MUL_RUN) begin
                acc_reg    <= acc_step;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                count_reg  <= count_reg + 1'b1;
                if (mul_last) begin
                    res_reg   <= acc_step[BITS-1:0];
                    flags_reg <= {acc_step[BITS-1], (acc_step[BITS-1:0] == '0),
                                  (acc_step[2*BITS-1:BITS] != '0), 1'b0};
                    valid_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at BITS=8: single-cycle ops, back-to-back issue,
// multiply latency/backpressure, operand capture and mid-multiply reset.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    alu_seq_if #(.BITS(8)) bus ();

    alu_seq #(.BITS(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .alu   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.valid_i   = 1'b1;
        bus.control_i = op;
        bus.bus_a_i   = a;
        bus.bus_b_i   = b;
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        step();
        check("idle_valid", 32'(bus.valid_o), 32'd0);
    endtask

    // Issue one single-cycle op and check its result one cycle later.
    task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_s, input logic [3:0] exp_f);
        drive(op, a, b);
        step();
        $display("[TB] %s op=%0d a=%02h b=%02h -> s=%02h f=%04b v=%0b",
                 tag, op, a, b, bus.bus_s_o, bus.flags_o, bus.valid_o);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, "_s"},     32'(bus.bus_s_o), 32'(exp_s));
        check({tag, "_f"},     32'(bus.flags_o), 32'(exp_f));
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    endtask

    // Wait for valid_o after an accepted MUL; lat counts cycles after accept.
    task automatic wait_valid(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (bus.valid_o) break;
            if (!bus.ready_o) busy++;
        end
    endtask

    int lat, busy, pulses;

    initial begin
        bus.valid_i   = 1'b0;
        bus.control_i = 4'd0;
        bus.bus_a_i   = 8'd0;
        bus.bus_b_i   = 8'd0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_s",     32'(bus.bus_s_o), 32'd0);
        check("rst_f",     32'(bus.flags_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);

        // Back-to-back single-cycle ops
        single("add_ovf",  4'd0, 8'h7F, 8'h01, 8'h80, 4'b1001);
        single("sub_zero", 4'd1, 8'h05, 8'h05, 8'h00, 4'b0110);
        single("or",       4'd4, 8'hAA, 8'h55, 8'hFF, 4'b1000);
        idle();
        check("hold_s", 32'(bus.bus_s_o), 32'hFF);
        check("hold_f", 32'(bus.flags_o), 32'b1000);

        single("add_carry", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b0110);
        single("sub_borrow",4'd1, 8'h03, 8'h05, 8'hFE, 4'b1000);
        single("and",       4'd5, 8'hAA, 8'h55, 8'h00, 4'b0100);
        single("xor",       4'd6, 8'hF0, 8'hFF, 8'h0F, 4'b0000);
        single("not",       4'd7, 8'h0F, 8'h33, 8'hF0, 4'b1000);
        single("shl1",      4'd2, 8'h81, 8'd1,  8'h02, 4'b0010);
        single("shr8",      4'd3, 8'h81, 8'd8,  8'h00, 4'b0110);
        single("shl9",      4'd2, 8'hFF, 8'd9,  8'h00, 4'b0100);
        single("shr0",      4'd3, 8'h81, 8'd0,  8'h81, 4'b1000);
        single("shr3",      4'd3, 8'h8C, 8'd3,  8'h11, 4'b0010);
        single("illegal",   4'hC, 8'hAA, 8'h55, 8'h00, 4'b0100);
        idle();

        // MUL with a request held through the busy window
        drive(4'd8, 8'h10, 8'h11);
        step();
        check("mul_acc_ready", 32'(bus.ready_o), 32'd0);
        check("mul_acc_valid", 32'(bus.valid_o), 32'd0);
        drive(4'd0, 8'h01, 8'h02);
        wait_valid(lat, busy);
        $display("[TB] mul a=10 b=11 -> s=%02h f=%04b lat=%0d", bus.bus_s_o, bus.flags_o, lat);
        check("mul_lat",   32'(lat),  32'd8);
        check("mul_busy",  32'(busy + 1), 32'd8);
        check("mul_s",     32'(bus.bus_s_o), 32'h10);
        check("mul_f",     32'(bus.flags_o), 32'b0010);
        check("mul_ready", 32'(bus.ready_o), 32'd1);
        step();
        $display("[TB] held add a=01 b=02 -> s=%02h v=%0b", bus.bus_s_o, bus.valid_o);
        check("held_valid", 32'(bus.valid_o), 32'd1);
        check("held_s",     32'(bus.bus_s_o), 32'h03);
        check("held_f",     32'(bus.flags_o), 32'b0000);
        idle();

        // Operand capture: inputs change right after accept
        drive(4'd8, 8'h03, 8'h05);
        step();
        bus.valid_i = 1'b0;
        bus.bus_a_i = 8'hFF;
        bus.bus_b_i = 8'hFF;
        wait_valid(lat, busy);
        $display("[TB] mul a=03 b=05 -> s=%02h f=%04b lat=%0d", bus.bus_s_o, bus.flags_o, lat);
        check("cap_lat", 32'(lat), 32'd8);
        check("cap_s",   32'(bus.bus_s_o), 32'h0F);
        check("cap_f",   32'(bus.flags_o), 32'b0000);

        // Reset during the third cycle of a MUL
        drive(4'd8, 8'h10, 8'h11);
        step();
        bus.valid_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("[TB] mul aborted by reset -> s=%02h f=%04b r=%0b", bus.bus_s_o, bus.flags_o, bus.ready_o);
        check("abort_ready", 32'(bus.ready_o), 32'd1);
        check("abort_s",     32'(bus.bus_s_o), 32'd0);
        check("abort_f",     32'(bus.flags_o), 32'd0);
        check("abort_valid", 32'(bus.valid_o), 32'd0);
        pulses = 0;
        repeat (12) begin
            step();
            if (bus.valid_o) pulses++;
        end
        check("abort_nopulse", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, handshaked successor of the team's combinational ALU for the datapath's execute stage. Single-cycle operations (add, sub, shifts, logic) are issued one per cycle. An iterative shift-add multiply takes BITS cycles. Results and NZCV flags are registered and held; flags are genuinely computed instead of tied to zero.

Parameters:
BITS, 8, operand/result width (>= 2)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-high
valid_i  input  1  operation request
ready_o  output  1  block can accept a request this cycle
control_i  input  4  opcode, sampled on accept
bus_a_i  input  BITS  operand A, sampled on accept
bus_b_i  input  BITS  operand B, sampled on accept
bus_s_o  output  BITS  registered result, held until next result
flags_o  output  4  registered {N,Z,C,V} (bit3..bit0), held with bus_s_o
valid_o  output  1  one-cycle pulse: bus_s_o/flags_o updated this cycle

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE, bus_s_o=0, flags_o=0, valid_o=0, ready_o=1.
- Reset applied mid-multiply aborts the operation; no valid_o is produced for it.
- Accept: occurs on any edge where valid_i && ready_o. Operands and opcode are latched then. Later input changes have no effect on that operation.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 SHL: A<<B
  - 3 SHR: A>>B, logical
  - 4 OR, 5 AND, 6 XOR
  - 7 NOT: ~A, B ignored
  - 8 MUL: low BITS of A*B, unsigned
  - 9-15 illegal
- States: IDLE, MUL_RUN.
- IDLE, single-cycle op accepted at edge E0:
  - Result and flags are registered at E0; valid_o=1 for the cycle after E0.
  - State stays IDLE and ready_o stays 1, giving throughput of 1 op/cycle.
- IDLE, MUL accepted at edge E0:
  - State goes to MUL_RUN; ready_o=0 from E0 until the cycle after E_BITS.
  - Iteration counter runs 0..BITS-1, processing one multiplier bit per edge (E1..E_BITS) into a 2*BITS accumulator.
  - At E_BITS: result registered, valid_o=1 for the following cycle, state returns to IDLE, ready_o=1.
  - MUL latency is therefore BITS cycles from accept to valid_o.
- valid_i while ready_o=0 is ignored; the requester must hold it.
- bus_s_o and flags_o change only on edges that produce valid_o, or on reset.
- Flag rules (N = result MSB and Z = (result==0) for all legal ops):
  - ADD: C = carry out of bit BITS-1; V = signed overflow.
  - SUB: C = no-borrow (A >= B unsigned); V = signed overflow.
  - SHL/SHR: shift amount is the full unsigned B.
    - Amount 0: result A, C=0.
    - Amount 1..BITS: C = last bit shifted out.
    - Amount > BITS: result 0, C=0.
    - V=0.
  - Logic ops and NOT: C=0, V=0.
  - MUL: C=1 iff upper BITS of the full product are nonzero; V=0.
  - Illegal opcode: accepted as a single-cycle op; result 0, flags 4'b0100.

Test Plan:
- BITS=8, ADD A=0x7F B=0x01 -> next cycle valid_o=1, bus_s_o=0x80, flags_o=4'b1001; ready_o stays 1.
- SUB A=0x05 B=0x05 accepted on the cycle right after an ADD (back-to-back) -> valid_o on two consecutive cycles; second gives bus_s_o=0x00, flags_o=4'b0110.
- MUL A=0x10 B=0x11 -> ready_o=0 for 8 cycles, valid_o exactly 8 cycles after accept, bus_s_o=0x10, flags_o=4'b0010. valid_i held high during the busy window is accepted only when ready_o returns to 1.
- SHL A=0x81 B=1 -> 0x02, flags 4'b0010. SHR A=0x81 B=8 -> 0x00, flags 4'b0110. SHL A=0xFF B=9 -> 0x00, flags 4'b0100.
- rst_i=1 on the 3rd cycle of a MUL -> next cycle ready_o=1, bus_s_o=0, flags_o=0, and no valid_o pulse follows for the aborted multiply.
- Opcode 0xC with A=0xAA B=0x55 -> 1-cycle latency, bus_s_o=0x00, flags_o=4'b0100. Changing bus_a_i right after accept of MUL A=3 B=5 still yields 0x0F.
